// File: rtl/pdp8_mem_arb_pkg.sv
// Shared types for the PDP-8 SRAM arbiter: FSM states, owner codes,
// bus widths, the latched request payload and the odd-parity helper.
package pdp8_mem_arb_pkg;

    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned DATA_W  = 12;
    localparam int unsigned IO_W    = 16;
    localparam int unsigned RAM_A_W = 18;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Bit that makes the total count of ones (data + parity) odd.
    function automatic logic odd_par(input logic [DATA_W-1:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/pdp8_sram_phy.sv
// SRAM physical sequencer: latches the granted address/data, registers
// the CE/OE/WE/UB/LB strobes from the arbiter's next state, owns the
// ram1_io tristate and presents the read word and its parity check.
// Optional feature macro: MEM_PARITY_EN (odd parity in ram1_io[12]).
// Ports:
//   clk, reset_n         clock, async active-low reset
//   load                 grant strobe; latch req this cycle
//   req                  granted request payload
//   state_nxt            arbiter next state (drives strobe registers)
//   acc_wr               latched direction of the current access
//   ram_a, ram_*_n       SRAM address and strobes (registered)
//   ram1_io              SRAM data bus
//   rd_word_c            read data on the bus
//   rd_par_err_c         read parity mismatch (0 without MEM_PARITY_EN)
module pdp8_sram_phy
    import pdp8_mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  mem_req_t           req,
    input  state_e             state_nxt,
    output logic               acc_wr,
    output logic [RAM_A_W-1:0] ram_a,
    output logic               ram_oe_n,
    output logic               ram_we_n,
    output logic               ram1_ce_n,
    output logic               ram1_ub_n,
    output logic               ram1_lb_n,
    inout  wire  [IO_W-1:0]    ram1_io,
    output logic [DATA_W-1:0]  rd_word_c,
    output logic               rd_par_err_c
);

    logic [DATA_W-1:0] wdata_q;
    logic              drv;
    logic [IO_W-1:0]   io_out;
    logic              wr_eff_c;
    logic              active_c;
    logic              unused_io;

    // On the grant edge the latch is not yet loaded, so use the incoming direction.
    assign wr_eff_c = load ? req.wr : acc_wr;
    assign active_c = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE);

    // Strobe and data-enable registers; reset releases the bus immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_wr    <= 1'b0;
            wdata_q   <= '0;
            ram_a     <= '0;
            ram1_ce_n <= 1'b1;
            ram1_ub_n <= 1'b1;
            ram1_lb_n <= 1'b1;
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            drv       <= 1'b0;
        end else begin
            if (load) begin
                acc_wr  <= req.wr;
                wdata_q <= req.wdata;
                ram_a   <= {3'b000, req.addr};
            end
            ram1_ce_n <= !active_c;
            ram1_ub_n <= !active_c;
            ram1_lb_n <= !active_c;
            ram_oe_n  <= !((state_nxt == ST_STROBE) && !wr_eff_c);
            ram_we_n  <= !((state_nxt == ST_STROBE) && wr_eff_c);
            drv       <= active_c && wr_eff_c;
        end
    end

`ifdef MEM_PARITY_EN
    assign io_out       = {3'b000, odd_par(wdata_q), wdata_q};
    assign rd_par_err_c = ram1_io[DATA_W] != odd_par(ram1_io[DATA_W-1:0]);
    assign unused_io    = ^ram1_io[IO_W-1:DATA_W+1];
`else
    assign io_out       = {4'b0000, wdata_q};
    assign rd_par_err_c = 1'b0;
    assign unused_io    = ^ram1_io[IO_W-1:DATA_W];
`endif

    assign ram1_io   = drv ? io_out : {IO_W{1'bz}};
    assign rd_word_c = ram1_io[DATA_W-1:0];

endmodule

// File: rtl/pdp8_mem_arb.sv
// PDP-8 main-memory arbiter: shares the ram1 asynchronous SRAM bank
// between the CPU and a data-break (DMA) requester, one 12-bit word per
// access, IDLE -> SETUP -> STROBE x ACC_CYCLES -> DONE.
// DMA has priority unless MAX_BURST DMA grants have gone by while the
// CPU waited. Optional feature macro: MEM_PARITY_EN (read parity check).
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   cpu_req/wr/addr/wdata, cpu_rdata, cpu_ack   CPU request/ack port
//   dma_req/wr/addr/wdata, dma_rdata, dma_ack   data-break port
//   busy                              access in progress
//   parity_err                        one-cycle read parity pulse in DONE
//   ram_a, ram_oe_n, ram_we_n, ram1_*, ram2_ce_n   SRAM pins
module pdp8_mem_arb
    import pdp8_mem_arb_pkg::*;
#(
    parameter int unsigned ACC_CYCLES = 2,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic               cpu_wr,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_ack,
    input  logic               dma_req,
    input  logic               dma_wr,
    input  logic [ADDR_W-1:0]  dma_addr,
    input  logic [DATA_W-1:0]  dma_wdata,
    output logic [DATA_W-1:0]  dma_rdata,
    output logic               dma_ack,
    output logic               busy,
    output logic               parity_err,
    output logic [RAM_A_W-1:0] ram_a,
    output logic               ram_oe_n,
    output logic               ram_we_n,
    output logic               ram1_ce_n,
    output logic               ram1_ub_n,
    output logic               ram1_lb_n,
    inout  wire  [IO_W-1:0]    ram1_io,
    output logic               ram2_ce_n
);

    state_e            state, state_nxt;
    owner_e            owner, owner_nxt;
    logic [CNT_W-1:0]  scnt, scnt_nxt;
    logic [CNT_W-1:0]  burst, burst_nxt;
    logic              grant_cpu_c, grant_dma_c, load_c;
    logic              last_strobe_c;
    mem_req_t          grant_req_c;
    logic              acc_wr;
    logic [DATA_W-1:0] rd_word_c;
    logic              rd_par_err_c;

    assign ram2_ce_n     = 1'b1;
    assign last_strobe_c = (state == ST_STROBE) && (scnt == CNT_W'(ACC_CYCLES - 1));

    // Next-state, grant selection and burst accounting.
    always_comb begin
        state_nxt         = state;
        owner_nxt         = owner;
        scnt_nxt          = scnt;
        burst_nxt         = burst;
        grant_cpu_c       = 1'b0;
        grant_dma_c       = 1'b0;
        load_c            = 1'b0;
        grant_req_c.wr    = cpu_wr;
        grant_req_c.addr  = cpu_addr;
        grant_req_c.wdata = cpu_wdata;

        case (state)
            ST_IDLE: begin
                // A waiting CPU overrides DMA once the burst limit is reached.
                if (dma_req && !(cpu_req && (burst == CNT_W'(MAX_BURST)))) begin
                    grant_dma_c       = 1'b1;
                    grant_req_c.wr    = dma_wr;
                    grant_req_c.addr  = dma_addr;
                    grant_req_c.wdata = dma_wdata;
                end else if (cpu_req) begin
                    grant_cpu_c = 1'b1;
                end
                if (grant_cpu_c || grant_dma_c) begin
                    load_c    = 1'b1;
                    state_nxt = ST_SETUP;
                    owner_nxt = grant_dma_c ? OWN_DMA : OWN_CPU;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_STROBE;
                scnt_nxt  = '0;
            end
            ST_STROBE: begin
                if (last_strobe_c) begin
                    state_nxt = ST_DONE;
                end else begin
                    scnt_nxt = scnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (!cpu_req || grant_cpu_c) begin
            burst_nxt = '0;
        end else if (grant_dma_c && (burst != CNT_W'(MAX_BURST))) begin
            burst_nxt = burst + CNT_W'(1);
        end
    end

    // State and registered completion outputs; read data lands with the ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            owner      <= OWN_CPU;
            scnt       <= '0;
            burst      <= '0;
            busy       <= 1'b0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            scnt       <= scnt_nxt;
            burst      <= burst_nxt;
            busy       <= state_nxt != ST_IDLE;
            cpu_ack    <= last_strobe_c && (owner == OWN_CPU);
            dma_ack    <= last_strobe_c && (owner == OWN_DMA);
            parity_err <= last_strobe_c && !acc_wr && rd_par_err_c;
            if (last_strobe_c && !acc_wr) begin
                if (owner == OWN_CPU) begin
                    cpu_rdata <= rd_word_c;
                end else begin
                    dma_rdata <= rd_word_c;
                end
            end
        end
    end

    pdp8_sram_phy u_phy (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (load_c),
        .req          (grant_req_c),
        .state_nxt    (state_nxt),
        .acc_wr       (acc_wr),
        .ram_a        (ram_a),
        .ram_oe_n     (ram_oe_n),
        .ram_we_n     (ram_we_n),
        .ram1_ce_n    (ram1_ce_n),
        .ram1_ub_n    (ram1_ub_n),
        .ram1_lb_n    (ram1_lb_n),
        .ram1_io      (ram1_io),
        .rd_word_c    (rd_word_c),
        .rd_par_err_c (rd_par_err_c)
    );

endmodule

// File: tb/tb_pdp8_mem_arb.sv
// Directed self-checking bench for pdp8_mem_arb with a behavioural
// asynchronous SRAM model (ram1 bank) and hand-computed expectations.
// Honours MEM_PARITY_EN for the parity-related expectations.
module tb_pdp8_mem_arb;

    localparam int unsigned ACC = 2;
    localparam int unsigned LAT = ACC + 2;
`ifdef MEM_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_wr, dma_req, dma_wr;
    logic [14:0] cpu_addr, dma_addr;
    logic [11:0] cpu_wdata, dma_wdata;
    logic [11:0] cpu_rdata, dma_rdata;
    logic        cpu_ack, dma_ack, busy, parity_err;
    logic [17:0] ram_a;
    logic        ram_oe_n, ram_we_n, ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n;
    wire  [15:0] ram1_io;

    logic [15:0] mem [0:32767];
    logic        bd_we = 1'b0;
    logic [14:0] bd_addr = '0;
    logic [15:0] bd_data = '0;

    int n_chk = 0;
    int n_pass = 0;
    int we_low = 0;
    int par_cnt = 0;

    always #5 clk = ~clk;

    pdp8_mem_arb #(.ACC_CYCLES(ACC), .MAX_BURST(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .busy(busy), .parity_err(parity_err),
        .ram_a(ram_a), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .ram1_ce_n(ram1_ce_n), .ram1_ub_n(ram1_ub_n), .ram1_lb_n(ram1_lb_n),
        .ram1_io(ram1_io), .ram2_ce_n(ram2_ce_n)
    );

    // SRAM model: drives the bus while selected and output-enabled.
    assign ram1_io = (!ram1_ce_n && !ram_oe_n) ? mem[ram_a[14:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (!ram1_ce_n && !ram_we_n) mem[ram_a[14:0]] <= ram1_io;
    end

    always @(negedge clk) begin
        if (!ram_we_n) we_low++;
        if (parity_err) par_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic bd_write(input logic [14:0] a, input logic [15:0] v);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Starts in an IDLE cycle; returns at the negedge of the ack (DONE) cycle.
    task automatic access(input bit is_dma, input bit wr, input logic [14:0] a,
                          input logic [11:0] d, output int lat);
        @(negedge clk);
        if (is_dma) begin dma_req = 1'b1; dma_wr = wr; dma_addr = a; dma_wdata = d; end
        else        begin cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; end
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (is_dma ? dma_ack : cpu_ack) break;
        end
        if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
    endtask

    initial begin
        int lat, we0, p0, t, t_dma, t_cpu, n_before, n_after, ack_seen;
        reset_n = 1'b0;
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_wr = 0; dma_addr = '0; dma_wdata = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_strobes", {ram_oe_n, ram_we_n, ram1_ce_n, ram1_ub_n, ram1_lb_n, ram2_ce_n}, 6'b111111);
        check("rst_flags", {cpu_ack, dma_ack, busy, parity_err}, 4'b0000);
        check("rst_ram_a", ram_a, 18'h0);
        check("rst_rdata", {cpu_rdata, dma_rdata}, 24'h0);
        reset_n = 1'b1;

        // 1: CPU write then read at 15'o07777
        we0 = we_low;
        access(0, 1, 15'o07777, 12'o5252, lat);
        check("t1_wr_lat", lat, LAT);
        check("t1_busy_done", busy, 1'b1);
        check("t1_we_low_cycles", we_low - we0, ACC);
        check("t1_mem_word", mem[15'o07777], PAR_ON ? 16'h1AAA : 16'h0AAA);
        access(0, 0, 15'o07777, 12'o0, lat);
        check("t1_rd_lat", lat, LAT);
        check("t1_rdata", cpu_rdata, 12'o5252);
        @(negedge clk);
        check("t1_idle_busy", busy, 1'b0);

        // DMA alone
        access(1, 1, 15'o03000, 12'o1357, lat);
        check("dma_wr_lat", lat, LAT);
        access(1, 0, 15'o03000, 12'o0, lat);
        check("dma_rd_lat", lat, LAT);
        check("dma_rdata", dma_rdata, 12'o1357);
        check("dma_cpu_rdata_kept", cpu_rdata, 12'o5252);

        // 2: simultaneous requests, DMA first
        bd_write(15'o00200, 16'h0123);
        dma_req = 1; dma_wr = 1; dma_addr = 15'o00300; dma_wdata = 12'o4321;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 15'o00200;
        t_dma = -1; t_cpu = -1;
        for (t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (dma_ack && t_dma < 0) begin t_dma = t; dma_req = 0; end
            if (cpu_ack && t_cpu < 0) begin t_cpu = t; cpu_req = 0; end
            if (t_dma >= 0 && t_cpu >= 0) break;
        end
        dma_req = 0; cpu_req = 0;
        check("t2_dma_ack_cycle", t_dma, LAT);
        check("t2_cpu_after_dma", t_cpu - t_dma, ACC + 3);
        check("t2_cpu_rdata", cpu_rdata, 12'h123);
        check("t2_dma_rdata_kept", dma_rdata, 12'o1357);
        check("t2_mem_dma_wr", mem[15'o00300], 16'h08D1);

        // 3: DMA burst limit with a waiting CPU
        bd_write(15'o00400, 16'h0555);
        bd_write(15'o00500, 16'h0777);
        dma_req = 1; dma_wr = 0; dma_addr = 15'o00400;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 15'o00500;
        n_before = 0; n_after = 0; t_cpu = -1;
        for (t = 1; t <= 100; t++) begin
            @(negedge clk);
            if (cpu_ack && t_cpu < 0) begin t_cpu = t; cpu_req = 0; end
            if (dma_ack) begin
                if (t_cpu < 0) n_before++;
                else begin n_after++; dma_req = 0; break; end
            end
        end
        dma_req = 0; cpu_req = 0;
        check("t3_dma_before_cpu", n_before, 4);
        check("t3_cpu_ack_cycle", t_cpu, 5 * (ACC + 3) - 1);
        check("t3_dma_resumes", n_after, 1);
        check("t3_dma_rdata", dma_rdata, 12'h555);
        check("t3_cpu_rdata", cpu_rdata, 12'h777);
        repeat (3) @(negedge clk);

        // 4: reset during the strobe of a write
        cpu_req = 1; cpu_wr = 1; cpu_addr = 15'o01000; cpu_wdata = 12'o7070;
        repeat (2) @(negedge clk);
        check("t4_we_active", ram_we_n, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        check("t4_strobes_released", {ram_oe_n, ram_we_n, ram1_ce_n}, 3'b111);
        check("t4_io_released", dut.u_phy.drv, 1'b0);
        check("t4_busy_clear", busy, 1'b0);
        cpu_req = 0;
        ack_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpu_ack) ack_seen++;
            if (i == 2) reset_n = 1'b1;
        end
        check("t4_no_ack", ack_seen, 0);
        check("t4_rdata_cleared", cpu_rdata, 12'h0);
        bd_write(15'o02000, 16'h0246);
        access(0, 0, 15'o02000, 12'o0, lat);
        check("t4_post_rst_lat", lat, LAT);
        check("t4_post_rst_rdata", cpu_rdata, 12'h246);

        // 5: parity
        access(0, 1, 15'o00101, 12'o0000, lat);
        check("t5_par_bit_zero_word", mem[15'o00101], PAR_ON ? 16'h1000 : 16'h0000);
        access(0, 1, 15'o00100, 12'o0001, lat);
        @(negedge clk);
        bd_write(15'o00100, mem[15'o00100] ^ 16'h1000);
        p0 = par_cnt;
        access(0, 0, 15'o00100, 12'o0, lat);
        check("t5_par_in_done", parity_err, PAR_ON);
        check("t5_rdata", cpu_rdata, 12'o0001);
        @(negedge clk);
        check("t5_par_pulses", par_cnt - p0, PAR_ON ? 1 : 0);
        p0 = par_cnt;
        access(0, 0, 15'o00101, 12'o0, lat);
        @(negedge clk);
        check("t5_clean_read_no_par", par_cnt - p0, 0);

        // 6: address extremes
        bd_write(15'o77777, 16'h0ABC);
        bd_write(15'o00000, 16'h0DEF);
        access(0, 0, 15'o77777, 12'o0, lat);
        check("t6_ram_a_top", ram_a, 18'h07FFF);
        check("t6_rdata_top", cpu_rdata, 12'hABC);
        access(0, 0, 15'o00000, 12'o0, lat);
        check("t6_ram_a_zero", ram_a, 18'h00000);
        check("t6_rdata_zero", cpu_rdata, 12'hDEF);
        check("t6_ram2_ce_n", ram2_ce_n, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
